// File: rtl/cpu_pkg.sv
// Shared encodings and widths for the pipeline hazard controller.
package cpu_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned STATE_W     = 2;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned FLUSH_CNT_W = 8;
  localparam int unsigned WAIT_CNT_W  = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic ex_mem_stall;
    logic mem_wb_bubble;
    logic if_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle between the datapath stages and the hazard controller.
interface hazard_ctrl_if;
  import cpu_pkg::*;

  logic [REG_W-1:0]       ID_rA;
  logic [REG_W-1:0]       ID_rB_or_rD;
  logic                   ID_rA_used;
  logic                   ID_rB_used;
  logic                   ID_br_ctrl;
  logic [REG_W-1:0]       EX_rD;
  logic                   EX_wrEn;
  logic                   EX_memEn;
  logic                   EX_memwrEn;
  logic                   MEM_req;
  logic                   MEM_ready;
  logic                   cnt_clr;
  logic                   PC_stall;
  logic                   IF_ID_stall;
  logic                   ID_EX_bubble;
  logic                   EX_MEM_stall;
  logic                   MEM_WB_bubble;
  logic                   IF_flush;
  logic                   mem_timeout;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [STATE_W-1:0]     ctrl_state;

  modport master (
    output ID_rA, ID_rB_or_rD, ID_rA_used, ID_rB_used, ID_br_ctrl,
           EX_rD, EX_wrEn, EX_memEn, EX_memwrEn, MEM_req, MEM_ready, cnt_clr,
    input  PC_stall, IF_ID_stall, ID_EX_bubble, EX_MEM_stall, MEM_WB_bubble,
           IF_flush, mem_timeout, stall_cnt, flush_cnt, ctrl_state
  );

  modport slave (
    input  ID_rA, ID_rB_or_rD, ID_rA_used, ID_rB_used, ID_br_ctrl,
           EX_rD, EX_wrEn, EX_memEn, EX_memwrEn, MEM_req, MEM_ready, cnt_clr,
    output PC_stall, IF_ID_stall, ID_EX_bubble, EX_MEM_stall, MEM_WB_bubble,
           IF_flush, mem_timeout, stall_cnt, flush_cnt, ctrl_state
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use match: an EX-stage load whose destination feeds an ID-stage source.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb_or_rd,
  input  logic             id_ra_used,
  input  logic             id_rb_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wr_en,
  input  logic             ex_mem_en,
  input  logic             ex_memwr_en,
  output logic             load_use
);

  logic ex_is_load;
  logic src_match;

  // r0 gets no special treatment: a load to r0 still interlocks.
  assign ex_is_load = ex_mem_en & ~ex_memwr_en & ex_wr_en;
  assign src_match  = (id_ra_used & (id_ra == ex_rd)) |
                      (id_rb_used & (id_rb_or_rd == ex_rd));
  assign load_use   = ex_is_load & src_match;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush generation for the 5-stage pipeline, plus stall and
// flush statistics and a sticky data-memory timeout flag.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  logic [STATE_W-1:0]     state;
  logic [STATE_W-1:0]     next_state;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic [WAIT_CNT_W-1:0]  wait_inc;
  logic                   mem_timeout;
  logic                   mem_hold;
  logic                   load_use;
  pipe_ctrl_t             ctrl;

  hazard_detect u_detect (
    .id_ra       (bus.ID_rA),
    .id_rb_or_rd (bus.ID_rB_or_rD),
    .id_ra_used  (bus.ID_rA_used),
    .id_rb_used  (bus.ID_rB_used),
    .ex_rd       (bus.EX_rD),
    .ex_wr_en    (bus.EX_wrEn),
    .ex_mem_en   (bus.EX_memEn),
    .ex_memwr_en (bus.EX_memwrEn),
    .load_use    (load_use)
  );

  assign mem_hold = bus.MEM_req & ~bus.MEM_ready;

  // Priority mem_hold > load_use > branch flush; the state only tracks which
  // hold is in progress, so the unused encoding behaves like RUN.
  always_comb begin
    ctrl       = '0;
    next_state = ST_RUN;
    if (mem_hold) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_stall   = 1'b1;
      ctrl.ex_mem_stall  = 1'b1;
      ctrl.mem_wb_bubble = 1'b1;
      next_state         = ST_MEM_WAIT;
    end else if (load_use) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_stall   = 1'b1;
      ctrl.id_ex_bubble  = 1'b1;
      next_state         = ST_LU_STALL;
    end else begin
      ctrl.if_flush      = bus.ID_br_ctrl;
    end
    if (!reset) begin
      ctrl = '0;
    end
  end

  assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_CNT_W'(1);

  // Counters, wait tracking and the sticky timeout; clear beats increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= mem_hold ? wait_inc : '0;
      if (bus.cnt_clr) begin
        stall_cnt   <= '0;
        flush_cnt   <= '0;
        mem_timeout <= 1'b0;
      end else begin
        if (ctrl.pc_stall && (stall_cnt != '1)) begin
          stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
        if (ctrl.if_flush && (flush_cnt != '1)) begin
          flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
        end
        if (mem_hold && (wait_inc >= WAIT_CNT_W'(TIMEOUT))) begin
          mem_timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.PC_stall      = ctrl.pc_stall;
  assign bus.IF_ID_stall   = ctrl.if_id_stall;
  assign bus.ID_EX_bubble  = ctrl.id_ex_bubble;
  assign bus.EX_MEM_stall  = ctrl.ex_mem_stall;
  assign bus.MEM_WB_bubble = ctrl.mem_wb_bubble;
  assign bus.IF_flush      = ctrl.if_flush;
  assign bus.mem_timeout   = mem_timeout;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;
  assign bus.ctrl_state    = state;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the MEM_WAIT cycle count that sets mem_timeout (legal range 1..255).
REQ-002 SHALL have ports as listed below; one clock; reset is asynchronous and active-low.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ID_rA  in  [0:4]  ID source register A
- ID_rB_or_rD  in  [0:4]  ID second source (rB, or rD for M-type/branch)
- ID_rA_used  in  1  ID instruction reads rA
- ID_rB_used  in  1  ID instruction reads second source
- ID_br_ctrl  in  1  branch taken, resolved in ID
- EX_rD  in  [0:4]  EX destination
- EX_wrEn, EX_memEn, EX_memwrEn  in  1 each  EX control bits
- MEM_req  in  1  MEM stage holds a data-memory access
- MEM_ready  in  1  data memory completes the access this cycle
- cnt_clr  in  1  synchronous clear of the counters
- PC_stall, IF_ID_stall  out  1 each  hold PC / IF-ID register
- ID_EX_bubble  out  1  load NOP into ID-EX
- EX_MEM_stall  out  1  hold ID-EX and EX-MEM
- MEM_WB_bubble  out  1  load NOP into MEM-WB
- IF_flush  out  1  squash the IF-ID instruction
- mem_timeout  out  1  sticky timeout flag
- stall_cnt  out  [0:15]  saturating stall-cycle count
- flush_cnt  out  [0:7]  saturating flush count
- ctrl_state  out  [0:1]  current FSM state

Function
REQ-003 SHALL implement FSM states RUN=0, LU_STALL=1, MEM_WAIT=2; encoding 3 is unreachable and SHALL decode as RUN.
REQ-004 mem_hold = MEM_req & ~MEM_ready; load_use = EX_memEn & ~EX_memwrEn & EX_wrEn & ((ID_rA_used & ID_rA==EX_rD) | (ID_rB_used & ID_rB_or_rD==EX_rD)); r0 is not special.
REQ-005 Priority per cycle: mem_hold > load_use > branch flush.
REQ-006 mem_hold (any state): PC_stall=IF_ID_stall=EX_MEM_stall=MEM_WB_bubble=1, ID_EX_bubble=0, IF_flush=0; next state MEM_WAIT.
REQ-007 load_use with ~mem_hold: PC_stall=IF_ID_stall=ID_EX_bubble=1, IF_flush=0; next state LU_STALL.
REQ-008 LU_STALL: ~mem_hold returns to RUN; a fresh load_use re-enters LU_STALL.
REQ-009 MEM_WAIT: on the cycle MEM_ready=1, stall outputs deassert combinationally; next state RUN.
REQ-010 IF_flush = ID_br_ctrl & ~mem_hold & ~load_use, asserted the same cycle with zero latency; a branch held by a stall flushes on its first unstalled cycle.
REQ-011 All pipeline-control outputs SHALL be combinational from the current inputs; only the state, counters and flags are registered.
REQ-012 stall_cnt increments by 1 on each cycle with PC_stall=1 and saturates at 0xFFFF.
REQ-013 flush_cnt increments by 1 on each cycle with IF_flush=1 and saturates at 0xFF.
REQ-014 cnt_clr zeroes both counters and mem_timeout next edge; clear wins over a same-cycle increment.
REQ-015 An internal 8-bit wait counter counts consecutive MEM_WAIT cycles and clears on leaving MEM_WAIT; reaching TIMEOUT sets mem_timeout (sticky), which does not alter stalls.

Reset
REQ-016 reset=0 SHALL immediately force state RUN, counters 0, wait counter 0 and mem_timeout 0.
REQ-017 During reset, stall and bubble outputs SHALL be 0 and IF_flush SHALL be 0, regardless of inputs.
REQ-018 On reset release, the first rising edge SHALL evaluate normally from RUN; reset mid-MEM_WAIT abandons the wait.

Structure
REQ-019 State encodings, the TIMEOUT default and counter widths SHALL live in shared package cpu_pkg.
REQ-020 Match logic SHALL be sub-module hazard_detect (combinational, outputs load_use); the FSM and counters stay in hazard_ctrl.

Verification
REQ-021 Scenario 1: EX load rD=5 (wrEn,memEn=1, memwrEn=0), ID rA=5 used -> 1 cycle of PC_stall/IF_ID_stall/ID_EX_bubble, state LU_STALL, then RUN; stall_cnt=1.
REQ-022 Scenario 2: EX store with rD=5 and ID rA=5 -> no stall.
REQ-023 Scenario 3: MEM_req=1, MEM_ready low for 3 cycles -> EX_MEM_stall and MEM_WB_bubble for 3 cycles, state MEM_WAIT, RUN after ready; stall_cnt=3.
REQ-024 Scenario 4: ID_br_ctrl=1 with a load-use hazard -> IF_flush=0 during the stall, 1 on the next cycle; flush_cnt=1.
REQ-025 Scenario 5: TIMEOUT=4 and MEM_ready held low 6 cycles -> mem_timeout=1 after the 4th cycle and stays set; cnt_clr clears it.
REQ-026 Scenario 6: reset asserted asynchronously mid-MEM_WAIT -> outputs 0 and state RUN before the next edge; stall_cnt=0.
